packet_assembler: RTL and testbench
===================================

Name: packet_assembler

Overview:
- Parametrised, clocked successor to the demodulator's bit buffer.
- Collects demodulated bits one at a time into a PACKET_SIZE-bit word and hands finished words to the UART transmit path over a valid/ready handshake.
- Double-buffered: an assembly register and an output holding register, so reception continues while the previous packet drains.
- Adds selectable bit order, a fill-level output and sticky overflow detection.

Parameters:
- PACKET_SIZE, 8, bits per packet; legal range 2..64.
- LSB_FIRST, 1, 1: first received bit lands in packet[0]; 0: first received bit lands in packet[PACKET_SIZE-1].
- CNT_W, $clog2(PACKET_SIZE+1), width of the fill counter; derived, never overridden.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- bit_valid  in  1  demodulator has a decided bit this cycle.
- bit_data  in  1  the decided bit, qualified by bit_valid.
- clear  in  1  synchronous abort of the partial packet; also clears overflow.
- packet  out  PACKET_SIZE  completed packet; stable while packet_valid=1.
- packet_valid  out  1  holding register holds an unconsumed packet.
- packet_ready  in  1  UART accepts the packet when packet_valid & packet_ready.
- fill_count  out  CNT_W  bits currently held in the assembly register, 0..PACKET_SIZE.
- overflow  out  1  sticky; a bit was dropped because both registers were full.

Behaviour:
- Reset (reset_n=0, asynchronous) sets:
  - packet=0, packet_valid=0, fill_count=0, overflow=0.
  - Assembly register = 0.
- Accept rule: a bit is accepted on an edge when bit_valid=1, clear=0 and either:
  - fill_count<PACKET_SIZE, or
  - a transfer occurs on the same edge.
- Accepted bit placement:
  - LSB_FIRST=1: bit goes to assembly[fill_count].
  - LSB_FIRST=0: bit goes to assembly[PACKET_SIZE-1-fill_count].
  - fill_count increments by 1.
- Transfer condition: fill_count==PACKET_SIZE and (packet_valid==0 or packet_ready==1) on the same edge, with clear=0.
- Transfer action:
  - packet <= assembly and packet_valid <= 1.
  - fill_count <= 0, or 1 if a bit is accepted on that edge; that bit takes the first position of the new packet.
- Consume: on packet_valid & packet_ready with no transfer, packet_valid <= 0. packet keeps its last value; it is not cleared.
- Latency: from the edge accepting the final bit to packet_valid=1 is 1 further edge when the holding register is free.
  - Minimum back-to-back throughput: one packet per PACKET_SIZE bit_valid cycles, with no bubbles required.
- Stall: fill_count==PACKET_SIZE and no transfer possible:
  - The assembly register is frozen.
  - A bit_valid=1 on such an edge is dropped and overflow <= 1.
- Overflow persistence: overflow stays 1 until clear or reset. It is never cleared by a handshake.
- clear=1 (synchronous):
  - fill_count <= 0, assembly <= 0, overflow <= 0.
  - clear has priority over bit_valid and over any pending transfer; the bit on that edge is discarded and not counted as overflow.
  - Holding register, packet and packet_valid are unaffected; a pending packet still drains normally.
- Simultaneous consume and transfer on one edge: packet loads the new word and packet_valid stays 1.
- Reset mid-packet: all partial and held data is lost and no packet_valid pulse is produced.
- Width rules:
  - fill_count never exceeds PACKET_SIZE.
  - Index arithmetic is performed at CNT_W bits; no wrap-around is possible by construction.
- No combinational path from any input to any output: all outputs are registered.

Decomposition:
- Shared package bpsk_pkg holds:
  - default PACKET_SIZE constant, shared with the UART transmitter.
  - a count-width function equivalent to $clog2(N+1).
  - bit-order enum BIT_ORDER_LSB/BIT_ORDER_MSB mapped onto LSB_FIRST.
- No sub-module is natural: the assembly and holding registers are small.
- Keep a single module with two always blocks:
  - assembly/counter/overflow.
  - holding/handshake.

Test Plan:
- PACKET_SIZE=8, LSB_FIRST=1, packet_ready=1; feed bits 1,0,1,1,0,0,1,0 on consecutive cycles -> packet=8'h4D with packet_valid high for 1 cycle, 1 edge after the 8th bit; fill_count reads 1..8 then 0.
- Same bits with LSB_FIRST=0 -> packet=8'hB2.
- packet_ready=0, stream 17 bits -> first packet held at 8'h4D, second assembly full (fill_count=8); the 17th bit is dropped and overflow=1. Raise packet_ready -> second packet transfers on the next edge; overflow stays 1 until clear.
- Continuous 32-bit stream, packet_ready=1 -> 4 packets with no dropped bits. The 9th bit arriving on the transfer edge lands in bit 0 of packet 2; fill_count=1 after that edge.
- Feed 5 bits then clear=1 with bit_valid=1 on the same cycle -> fill_count=0 and overflow=0; next 8 bits form a clean packet; no stale bits appear.
- Assert reset_n=0 asynchronously mid-packet (fill_count=3, packet_valid=1) -> all outputs are 0 immediately, without waiting for a clock edge; after release, normal assembly resumes from bit 0.

Source files
------------

// File: rtl/bpsk_pkg.sv
// Shared BPSK receive/transmit definitions.
// - PACKET_SIZE_DEF : default packet width, also used by the UART transmitter.
// - cnt_width()     : bits needed to count 0..n inclusive.
// - bit_order_e     : packet bit order, mapped onto the LSB_FIRST parameter.
package bpsk_pkg;

  localparam int PACKET_SIZE_DEF = 8;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  typedef enum logic {
    BIT_ORDER_MSB = 1'b0,
    BIT_ORDER_LSB = 1'b1
  } bit_order_e;

endpackage

// File: rtl/packet_assembler.sv
// Serial-bit packet assembler with double buffering.
// Collects demodulated bits into an assembly register. Each full word moves
// into a holding register and drains over a valid/ready handshake while the
// next word is being collected.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   bit_valid      a demodulated bit is present this cycle
//   bit_data       the bit, qualified by bit_valid
//   clear          synchronous abort of the partial word, also clears overflow
//   packet         finished word, stable while packet_valid=1
//   packet_valid   holding register holds an unconsumed word
//   packet_ready   consumer accepts the word when packet_valid & packet_ready
//   fill_count     number of bits in the assembly register (0..PACKET_SIZE)
//   overflow       sticky: a bit was dropped because both registers were full
module packet_assembler
  import bpsk_pkg::*;
#(
  parameter int PACKET_SIZE = PACKET_SIZE_DEF,
  parameter bit LSB_FIRST   = 1'b1,
  parameter int CNT_W       = cnt_width(PACKET_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   bit_valid,
  input  logic                   bit_data,
  input  logic                   clear,
  output logic [PACKET_SIZE-1:0] packet,
  output logic                   packet_valid,
  input  logic                   packet_ready,
  output logic [CNT_W-1:0]       fill_count,
  output logic                   overflow
);

  localparam bit_order_e       ORDER = LSB_FIRST ? BIT_ORDER_LSB : BIT_ORDER_MSB;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(PACKET_SIZE);
  localparam logic [CNT_W-1:0] TOP   = CNT_W'(PACKET_SIZE - 1);

  logic [PACKET_SIZE-1:0] assembly, assembly_nxt;
  logic                   full, transfer, accept;
  logic [CNT_W-1:0]       slot, pos;

  assign full     = (fill_count == FULL);
  // A full assembly register empties into the holding register whenever the
  // holding register is empty or being drained on this same edge.
  assign transfer = ~clear & full & (~packet_valid | packet_ready);
  assign accept   = bit_valid & ~clear & (~full | transfer);

  // On a transfer edge the incoming bit starts the next word at slot 0.
  assign slot = transfer ? '0 : fill_count;
  assign pos  = (ORDER == BIT_ORDER_LSB) ? slot : TOP - slot;

  always_comb begin
    assembly_nxt = transfer ? '0 : assembly;
    for (int i = 0; i < PACKET_SIZE; i++)
      if (CNT_W'(i) == pos) assembly_nxt[i] = bit_data;
  end

  // Assembly register, fill counter, overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      assembly   <= '0;
      fill_count <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      assembly   <= '0;
      fill_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (accept) begin
        assembly   <= assembly_nxt;
        fill_count <= slot + CNT_W'(1);
      end else if (transfer) begin
        assembly   <= '0;
        fill_count <= '0;
      end
      // With clear excluded above, a rejected bit means both registers full.
      if (bit_valid && !accept) overflow <= 1'b1;
    end
  end

  // Holding register and output handshake; clear does not touch it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      packet       <= '0;
      packet_valid <= 1'b0;
    end else if (transfer) begin
      packet       <= assembly;
      packet_valid <= 1'b1;
    end else if (packet_valid && packet_ready) begin
      packet_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_packet_assembler.sv
// Self-checking bench for packet_assembler: one LSB-first and one MSB-first
// instance share all inputs and are compared against a queue-based model.
module tb_packet_assembler;

  localparam int PS = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          bit_valid = 1'b0, bit_data = 1'b0, clear = 1'b0;
  logic          packet_ready = 1'b0;
  logic [PS-1:0] pkt_l, pkt_m;
  logic          pv_l, pv_m, ov_l, ov_m;
  logic [CW-1:0] fc_l, fc_m;

  packet_assembler #(.PACKET_SIZE(PS), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .bit_valid(bit_valid), .bit_data(bit_data),
    .clear(clear), .packet(pkt_l), .packet_valid(pv_l),
    .packet_ready(packet_ready), .fill_count(fc_l), .overflow(ov_l));

  packet_assembler #(.PACKET_SIZE(PS), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset_n(reset_n), .bit_valid(bit_valid), .bit_data(bit_data),
    .clear(clear), .packet(pkt_m), .packet_valid(pv_m),
    .packet_ready(packet_ready), .fill_count(fc_m), .overflow(ov_m));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: received bits in arrival order, plus the held word in both orders.
  int            q[$];
  logic [PS-1:0] m_l = '0, m_m = '0;
  logic          m_pv = 1'b0, m_ov = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("packet_lsb",   64'(pkt_l), 64'(m_l));
    chk("packet_msb",   64'(pkt_m), 64'(m_m));
    chk("valid_lsb",    64'(pv_l),  64'(m_pv));
    chk("valid_msb",    64'(pv_m),  64'(m_pv));
    chk("fill_lsb",     64'(fc_l),  64'(q.size()));
    chk("fill_msb",     64'(fc_m),  64'(q.size()));
    chk("overflow_lsb", 64'(ov_l),  64'(m_ov));
    chk("overflow_msb", 64'(ov_m),  64'(m_ov));
  endtask

  task automatic model_reset();
    q.delete();
    m_l = '0; m_m = '0; m_pv = 1'b0; m_ov = 1'b0;
  endtask

  // Advance the model by one rising edge using the current inputs.
  task automatic model_edge();
    bit drained;
    drained = m_pv && packet_ready;
    if (clear) begin
      q.delete();
      m_ov = 1'b0;
      if (drained) m_pv = 1'b0;
    end else begin
      if (q.size() == PS && (!m_pv || packet_ready)) begin
        m_l = '0; m_m = '0;
        for (int k = 0; k < PS; k++) begin
          m_l[k]        = q[k][0];
          m_m[PS-1-k]   = q[k][0];
        end
        m_pv = 1'b1;
        q.delete();
      end else if (drained) begin
        m_pv = 1'b0;
      end
      if (bit_valid) begin
        if (q.size() < PS) q.push_back(int'(bit_data));
        else m_ov = 1'b1;
      end
    end
  endtask

  task automatic tick(input logic bv, input logic bd, input logic clr, input logic rdy);
    bit_valid = bv; bit_data = bd; clear = clr; packet_ready = rdy;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  logic [PS-1:0] pat;

  initial begin
    pat = 8'b0100_1101;  // bits fed in order 1,0,1,1,0,0,1,0

    // Reset state
    #12;
    model_reset();
    check_all();
    reset_n = 1'b1;

    // Single packet, ready high
    for (int i = 0; i < PS; i++) tick(1'b1, pat[i], 1'b0, 1'b1);
    chk("fill_after_8", 64'(fc_l), 64'd8);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("pkt_4d", 64'(pkt_l), 64'h4D);
    chk("pkt_b2", 64'(pkt_m), 64'hB2);
    chk("valid_pulse", 64'(pv_l), 64'd1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("valid_drop", 64'(pv_l), 64'd0);

    // Backpressure: 17 bits with ready low
    for (int i = 0; i < 17; i++) tick(1'b1, pat[i % PS], 1'b0, 1'b0);
    chk("stall_fill", 64'(fc_l), 64'd8);
    chk("stall_ovf", 64'(ov_l), 64'd1);
    chk("stall_held", 64'(pkt_l), 64'h4D);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("drain_valid", 64'(pv_l), 64'd1);
    chk("ovf_sticky", 64'(ov_l), 64'd1);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    chk("ovf_cleared", 64'(ov_l), 64'd0);

    // Continuous 32-bit stream, no dropped bits
    for (int i = 0; i < 32; i++) begin
      tick(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      if (i == 8) chk("ninth_bit_fill", 64'(fc_l), 64'd1);
    end
    chk("stream_no_ovf", 64'(ov_l), 64'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // Five bits, then clear together with a valid bit
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clear_fill", 64'(fc_l), 64'd0);
    for (int i = 0; i < PS; i++) tick(1'b1, pat[i], 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clean_pkt", 64'(pkt_l), 64'h4D);

    // Random traffic against the model
    for (int i = 0; i < 600; i++)
      tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 2) != 0));

    // Asynchronous reset mid-packet with a held word
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < PS; i++) tick(1'b1, pat[i], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_fill", 64'(fc_l), 64'd3);
    chk("pre_rst_valid", 64'(pv_l), 64'd1);
    bit_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #3 reset_n = 1'b1;
    #1;
    check_all();
    for (int i = 0; i < PS; i++) tick(1'b1, pat[i], 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("post_rst_pkt", 64'(pkt_l), 64'h4D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
